axis_s: RTL
===========

AXIS_S -- requirements
Module: axis_s

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32: data beat width in bits.
REQ-002 The module SHALL have parameter LEN_WIDTH, default 10: width of the frame-length configuration and beat counter.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The module SHALL have port s_axis_tdata, input, WIDTH bits: upstream AXI-Stream data.
REQ-006 The module SHALL have port s_axis_tvalid, input, 1 bit: upstream beat valid.
REQ-007 The module SHALL have port s_axis_tready, output, 1 bit: this block can accept a beat.
REQ-008 The module SHALL have port s_axis_tlast, input, 1 bit: upstream end of frame.
REQ-009 The module SHALL have port pop, input, 1 bit: downstream read request.
REQ-010 The module SHALL have port valid_out, output, 1 bit: data_out is valid this cycle.
REQ-011 The module SHALL have port data_out, output, WIDTH bits: downstream beat data.
REQ-012 The module SHALL have port last_out, output, 1 bit: the beat on data_out terminated its frame.
REQ-013 The module SHALL have port config_valid, input, 1 bit: arm reception of one frame.
REQ-014 The module SHALL have port config_len, input, LEN_WIDTH bits: expected beats per frame, 1..2^LEN_WIDTH-1.
REQ-015 The module SHALL have port done, output, 1 bit: one-cycle pulse at frame termination.
REQ-016 The module SHALL have port err_early, output, 1 bit: tlast arrived before the expected length; valid with done.
REQ-017 The module SHALL have port err_late, output, 1 bit: expected length reached without tlast; valid with done.
REQ-018 The module SHALL have port err_cfg, output, 1 bit: one-cycle pulse when config_len==0 is rejected.
REQ-019 The module SHALL have port len_rcv, output, LEN_WIDTH bits: beats accepted in the last terminated frame.

Function
REQ-020 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-021 In IDLE, config_valid with config_len!=0 SHALL latch len_store=config_len, set count=1 and move to RUN next cycle.
REQ-022 In IDLE, config_valid with config_len==0 SHALL stay in IDLE and pulse err_cfg for one cycle.
REQ-023 config_valid in RUN SHALL be ignored.
REQ-024 s_axis_tready SHALL be (state==RUN) && (~full || pop); it SHALL be 0 in IDLE.
REQ-025 A beat SHALL be accepted when s_axis_tvalid && s_axis_tready; {term, tdata} is pushed into the buffer.
REQ-026 term SHALL be s_axis_tlast || (count==len_store) for the accepted beat.
REQ-027 On an accepted beat with term==0, count SHALL increment by 1.
REQ-028 On an accepted beat with term==1, the FSM SHALL return to IDLE, len_rcv=count, and count SHALL reset to 1.
REQ-029 On that same cycle, done SHALL pulse on the following cycle.
REQ-030 On that terminating beat, err_early SHALL be (tlast && count<len_store).
REQ-031 On that terminating beat, err_late SHALL be (!tlast && count==len_store).
REQ-032 err_early and err_late SHALL hold their values until the next done pulse.
REQ-033 Upstream beats after termination SHALL NOT be accepted until the block is reconfigured.
REQ-034 The buffer SHALL hold 4 entries; an accepted beat SHALL become visible downstream one cycle after acceptance.
REQ-035 valid_out SHALL be pop && ~empty; data_out and last_out SHALL present the head entry in the same cycle (peek); the entry is removed when valid_out==1.
REQ-036 pop while empty SHALL have no effect.
REQ-037 A simultaneous push and pop when full SHALL succeed with occupancy unchanged.
REQ-038 Downstream draining SHALL be independent of FSM state; buffered beats remain readable in IDLE.

Reset
REQ-039 On rst_n low, regardless of operation in progress: state=IDLE, count=1, len_store=0, len_rcv=0, buffer empty.
REQ-040 During reset: done=0, err_early=0, err_late=0, err_cfg=0, s_axis_tready=0, valid_out=0.

Structure
REQ-041 The IDLE/RUN state typedef SHALL be placed in shared package axis_pkg, alongside the transmitter's states.
REQ-042 The buffer SHALL be the existing d0fifo instance: WIDTH+1 wide, SIZE 4, FULL/EMPTY/VALID/PEEK enabled, FLUSH off.
REQ-043 No other sub-module SHALL be used.

Verification
REQ-044 Scenario: config_len=4; 4 beats 0xA0..0xA3 with tlast on the 4th -> done, len_rcv=4, no errors; pops return A0..A3 with last_out only on A3.
REQ-045 Scenario: config_len=5; tlast on beat 3 -> done, err_early=1, len_rcv=3, last_out on beat 3, beat 4 not accepted.
REQ-046 Scenario: config_len=2; no tlast -> terminates after beat 2 with err_late=1, len_rcv=2.
REQ-047 Scenario: config_len=8; pop held low -> tready drops after 4 beats; pop asserted every cycle -> one beat per cycle, no data loss.
REQ-048 Scenario: config_len=0 -> err_cfg pulse, state stays IDLE; rst_n low mid-frame after 2 of 6 beats -> all outputs reset, buffer empty.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI-Stream endpoint types: receiver and transmitter FSM states and buffer depth.
// Combinational declarations only; no latency or flow-control behaviour of its own.
package axis_pkg;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_RUN  = 1'b1
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_RUN  = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_t;

  localparam int AXIS_BUF_DEPTH = 4;

endpackage

// File: rtl/d0fifo.sv
// Generic synchronous FIFO with optional full/empty/valid/peek/flush; write visible one cycle later.
// Push while full is taken only when a pop retires the head entry in the same cycle.
module d0fifo #(
  parameter int WIDTH    = 8,
  parameter int SIZE     = 4,
  parameter bit FULL_EN  = 1'b1,
  parameter bit EMPTY_EN = 1'b1,
  parameter bit VALID_EN = 1'b1,
  parameter bit PEEK_EN  = 1'b1,
  parameter bit FLUSH_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic             valid
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [SIZE];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             is_full;
  logic             is_empty;
  logic             do_push;
  logic             do_pop;
  logic             flush_i;

  assign is_full  = (cnt == CW'(SIZE));
  assign is_empty = (cnt == '0);
  assign do_pop   = pop && !is_empty;
  assign do_push  = push && (!is_full || do_pop);
  assign flush_i  = FLUSH_EN ? flush : 1'b0;

  assign full  = FULL_EN  ? is_full  : 1'b0;
  assign empty = EMPTY_EN ? is_empty : 1'b0;
  assign valid = VALID_EN ? do_pop   : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == AW'(SIZE - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(SIZE - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  generate
    if (PEEK_EN) begin : g_peek
      assign pop_dat = mem[rd_ptr];
    end else begin : g_reg
      logic [WIDTH-1:0] dat_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dat_q <= '0;
        end else if (do_pop) begin
          dat_q <= mem[rd_ptr];
        end
      end
      assign pop_dat = dat_q;
    end
  endgenerate

endmodule

// File: rtl/axis_s.sv
// AXI-Stream frame receiver: length-checked frames into a 4-entry peek buffer, beats visible 1 cycle after accept.
// tready follows buffer space (or a same-cycle pop) while armed; done/errors are registered, 1 cycle after the last beat.
module axis_s
  import axis_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LEN_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic                 pop,
  output logic                 valid_out,
  output logic [WIDTH-1:0]     data_out,
  output logic                 last_out,
  input  logic                 config_valid,
  input  logic [LEN_WIDTH-1:0] config_len,
  output logic                 done,
  output logic                 err_early,
  output logic                 err_late,
  output logic                 err_cfg,
  output logic [LEN_WIDTH-1:0] len_rcv
);

  rx_state_t            state;
  logic [LEN_WIDTH-1:0] count;
  logic [LEN_WIDTH-1:0] len_store;
  logic                 buf_full;
  logic                 buf_empty;
  logic                 beat_acc;
  logic                 term;
  logic [WIDTH:0]       buf_out;

  // A pop in the same cycle frees a slot, so a full buffer need not stall upstream.
  assign s_axis_tready = (state == RX_RUN) && (!buf_full || pop);
  assign beat_acc      = s_axis_tvalid && s_axis_tready;
  assign term          = s_axis_tlast || (count == len_store);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      count     <= LEN_WIDTH'(1);
      len_store <= '0;
      len_rcv   <= '0;
      done      <= 1'b0;
      err_early <= 1'b0;
      err_late  <= 1'b0;
      err_cfg   <= 1'b0;
    end else begin
      done    <= 1'b0;
      err_cfg <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (config_valid) begin
            if (config_len != '0) begin
              len_store <= config_len;
              count     <= LEN_WIDTH'(1);
              state     <= RX_RUN;
            end else begin
              err_cfg <= 1'b1;
            end
          end
        end
        RX_RUN: begin
          if (beat_acc) begin
            if (term) begin
              state     <= RX_IDLE;
              len_rcv   <= count;
              count     <= LEN_WIDTH'(1);
              done      <= 1'b1;
              err_early <= s_axis_tlast && (count < len_store);
              err_late  <= !s_axis_tlast && (count == len_store);
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  d0fifo #(
    .WIDTH    (WIDTH + 1),
    .SIZE     (AXIS_BUF_DEPTH),
    .FULL_EN  (1'b1),
    .EMPTY_EN (1'b1),
    .VALID_EN (1'b1),
    .PEEK_EN  (1'b1),
    .FLUSH_EN (1'b0)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (1'b0),
    .push     (beat_acc),
    .push_dat ({term, s_axis_tdata}),
    .pop      (pop),
    .pop_dat  (buf_out),
    .full     (buf_full),
    .empty    (buf_empty),
    .valid    (valid_out)
  );

  assign data_out = buf_out[WIDTH-1:0];
  assign last_out = buf_out[WIDTH];

endmodule
